// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and div_unit.
// The master drives the operands and the start pulse. The slave (div_unit)
// returns the result, busy and done.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (output start, op, a, b, input  result, busy, done);
    modport slave  (input  start, op, a, b, output result, busy, done);
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// It produces one quotient bit per cycle by running a trial subtraction
// through a WIDTH+1 bit ripple-carry adder held in subtract mode.
// Optional macro DIV_EARLY_OUT_EN: a divide by zero or a signed overflow skips
// the iteration and completes on the accepting edge.

// div_rca: ripple-carry adder. With sub_en=1 it computes x - y.
module div_rca #(
    parameter int N = 33
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sub_en,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] c;

    // Chain of full adders; in subtract mode y is inverted and the carry-in is set
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = sub_en;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i]   = x[i] ^ (y[i] ^ sub_en) ^ c[i];
            c[i + 1] = (x[i] & (y[i] ^ sub_en)) | (c[i] & (x[i] ^ (y[i] ^ sub_en)));
        end
        cout = c[N];
    end
endmodule

module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t           state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [CW-1:0]    cnt;
    logic             rem_sel;
    logic             sa_r;
    logic             sb_r;
    logic             bz_r;

    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   trial;
    logic             trial_cout;
    logic             ge;
    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero_in;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             accept;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Shifting the whole {rem, quo} pair drops rem's top bit, which is always 0
    assign shifted = {rem, quo} << 1;

    div_rca #(.N(WIDTH + 1)) u_rca (
        .x      (shifted[2*WIDTH:WIDTH]),
        .y      ({1'b0, divisor}),
        .sub_en (1'b1),
        .sum    (trial),
        .cout   (trial_cout)
    );

    // Operand conditioning, trial decision and sign fixup
    always_comb begin
        ge        = trial_cout & ~trial[WIDTH];
        in_signed = ~bus.op[0];
        a_neg     = in_signed & bus.a[WIDTH-1];
        b_neg     = in_signed & bus.b[WIDTH-1];
        abs_a     = a_neg ? -bus.a : bus.a;
        abs_b     = b_neg ? -bus.b : bus.b;
        b_zero_in = (bus.b == '0);
        accept    = bus.start & ((state == IDLE) | (state == DONE));
        // A zero divisor leaves the all-ones quotient un-negated
        q_fix     = ((sa_r ^ sb_r) & ~bz_r) ? -quo : quo;
        r_fix     = sa_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

`ifdef DIV_EARLY_OUT_EN
    logic             special;
    logic [WIDTH-1:0] special_res;

    // Divide by zero and signed overflow have fixed results known at accept time
    always_comb begin
        special     = b_zero_in |
                      (in_signed & (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) & (bus.b == '1));
        special_res = bus.op[1] ? (b_zero_in ? bus.a : '0)
                                : (b_zero_in ? '1 : bus.a);
    end
`endif

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bus.result <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
            cnt        <= '0;
            rem_sel    <= 1'b0;
            sa_r       <= 1'b0;
            sb_r       <= 1'b0;
            bz_r       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: ;
                CALC: begin
                    rem <= ge ? trial : shifted[2*WIDTH:WIDTH];
                    quo <= shifted[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ge};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    bus.result <= rem_sel ? r_fix : q_fix;
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b1;
                    state      <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
            // Accepting from IDLE or DONE overrides the case branches above
            if (accept) begin
                rem_sel <= bus.op[1];
                sa_r    <= a_neg;
                sb_r    <= b_neg;
                bz_r    <= b_zero_in;
                rem     <= '0;
                quo     <= abs_a;
                divisor <= abs_b;
                cnt     <= CW'(WIDTH - 1);
`ifdef DIV_EARLY_OUT_EN
                if (special) begin
                    bus.result <= special_res;
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b1;
                    state      <= DONE;
                end else begin
                    bus.busy <= 1'b1;
                    state    <= CALC;
                end
`else
                bus.busy <= 1'b1;
                state    <= CALC;
`endif
            end
        end
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the execute stage beside the ALU.
- Each iteration drives the existing RCA adder in subtract mode (subEn=1) and consumes its result and cout to decide one quotient bit.
- The hazard/stall logic holds the pipeline while busy=1 and captures result when done=1.

Parameters:
- WIDTH, 32, operand/result width in bits; the internal RCA instance is WIDTH+1 bits wide.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request pulse; sampled only when the unit can accept.
- op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- a  input  WIDTH  dividend (rs1); sampled with start.
- b  input  WIDTH  divisor (rs2); sampled with start.
- result  output  WIDTH  quotient or remainder; registered; held until the next accepted start.
- busy  output  1  high from the accepting edge until done.
- done  output  1  one-cycle pulse; result is valid in that cycle.

Behaviour:
- Reset (async, any state): state=IDLE; result=0, busy=0, done=0; internal counter and registers cleared. A reset mid-operation discards the operation and no done is produced.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE: start=1 accepts the request.
  - Latch op, sign flags, |a|, |b| (magnitudes only for DIV/REM).
  - Remainder register (WIDTH+1 bits) = 0, counter = WIDTH-1, busy=1, go to CALC.
- CALC, one edge per iteration:
  - Shift {rem, quotient} left by 1.
  - Trial = rem_shifted − divisor through RCA with subEn=1, zero-extended to WIDTH+1 bits.
  - Trial sign bit 0: rem = trial, quotient LSB = 1. Otherwise keep rem, LSB = 0.
  - Counter decrements; at counter==0 go to FIXUP.
- FIXUP (one edge):
  - Quotient is negated when signed op and sign(a)≠sign(b).
  - Remainder takes sign of a when signed op.
  - result = quotient for DIV/DIVU, remainder for REM/REMU. Go to DONE.
- DONE: done=1, busy=0 for exactly one cycle.
  - start=1 in this cycle is accepted (back-to-back), going directly to CALC.
  - Otherwise go to IDLE.
- Latency: start accepted at edge 0; done is high in the cycle after edge WIDTH+1 (edge 33 for WIDTH=32); throughput one op per WIDTH+2 cycles.
- start while busy=1 (CALC/FIXUP) is ignored; no queueing. op, a and b changes after acceptance have no effect.
- Division by zero (b==0), RISC-V defined results, no trap:
  - DIV/DIVU quotient = all ones.
  - REM/REMU = a.
  - Produced by normal iteration plus FIXUP forcing; quotient negation is suppressed when b==0.
- Signed overflow (DIV/REM with a=−2^(WIDTH−1), b=−1): DIV = −2^(WIDTH−1), REM = 0.
- Magnitude of −2^(WIDTH−1) is represented correctly (unsigned WIDTH bits).
- result changes only at the FIXUP edge or reset.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE with start=1, if b==0 or signed overflow, skip CALC/FIXUP.
  - Load the special-case result directly and enter DONE on the accepting edge.
  - done is high in the next cycle, so latency is 1 cycle.
  - Normal operands keep full latency.
- Undefined: all operations, special cases included, take the full WIDTH+2 cycle latency with identical result values.

Test Plan:
- DIVU a=100, b=7 → result=14, done pulses exactly one cycle, in the cycle after edge 33; REMU same operands → 2.
- DIV a=−20, b=6 → −3 (0xFFFFFFFD); REM a=−20, b=6 → −2; REM a=20, b=−6 → 2.
- DIV a=5, b=0 → 0xFFFFFFFF; REMU a=5, b=0 → 5; with DIV_EARLY_OUT_EN, done is high the cycle after start, else after edge 33.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM same → 0.
- Pulse start with a=9, b=3 while busy mid-CALC (a=1000, b=10 in flight) → ignored, result=100; start asserted in the DONE cycle → accepted, second done 34 cycles later.
- Assert rst at cycle 10 of CALC → busy=0, done=0, result=0 immediately (async); no done follows; the next op completes normally.
